// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP definitions used by the TX scheduler and its neighbours.
package eth_pkg;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_WAIT_DONE = 2'd1,
    TX_GAP       = 2'd2
  } tx_sched_state_t;

  localparam logic        ARP_OPER_REQUEST = 1'b0;
  localparam logic        ARP_OPER_REPLY   = 1'b1;
  localparam logic [47:0] MAC_BROADCAST    = 48'hFFFF_FFFF_FFFF;

  // Requester slots on the round-robin arbiter.
  localparam int unsigned REQ_QUERY = 0;
  localparam int unsigned REQ_REPLY = 1;

endpackage

// File: rtl/eth_tx_sched_if.sv
// Requester, frame-builder and status signals of the ARP TX scheduler.
interface eth_tx_sched_if;
  logic        reply_req;
  logic [47:0] reply_mac;
  logic [31:0] reply_ip;
  logic        reply_ack;
  logic        query_req;
  logic [31:0] query_ip;
  logic        query_ack;
  logic        tx_frame_start;
  logic        tx_frame_done;
  logic [47:0] mac_d_addr;
  logic [31:0] ip_d_addr;
  logic        arp_oper;
  logic        busy;
  logic        timeout_err;
  logic [15:0] tx_count;

  modport master (
    output reply_req, reply_mac, reply_ip, query_req, query_ip, tx_frame_done,
    input  reply_ack, query_ack, tx_frame_start, mac_d_addr, ip_d_addr,
           arp_oper, busy, timeout_err, tx_count
  );

  modport slave (
    input  reply_req, reply_mac, reply_ip, query_req, query_ip, tx_frame_done,
    output reply_ack, query_ack, tx_frame_start, mac_d_addr, ip_d_addr,
           arp_oper, busy, timeout_err, tx_count
  );
endinterface

// File: rtl/arb_rr2.sv
// Two-input round-robin arbiter: on a tie the input not granted last wins.
module arb_rr2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);
  logic last_q;  // index of the most recent winner; resets to input 0

  // NOTE: grant_o is assigned before any branch so no latch is inferred.
  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = last_q ? 2'b01 : 2'b10;
    end
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b0;
    end else if (advance_i && (grant_o != 2'b00)) begin
      last_q <= grant_o[1];
    end
  end
endmodule

// File: rtl/eth_tx_sched.sv
// ARP transmit scheduler: grants reply/query requesters one frame at a time,
// then enforces the inter-frame gap and a watchdog on the frame builder.
module eth_tx_sched
  import eth_pkg::*;
#(
  parameter int unsigned IFG_CYCLES     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic          aclk,
  input  logic          areset,
  eth_tx_sched_if.slave bus
);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned GAP_W = $clog2(IFG_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYCLES - 1);

  localparam logic [1:0] S_IDLE      = TX_IDLE;
  localparam logic [1:0] S_WAIT_DONE = TX_WAIT_DONE;
  localparam logic [1:0] S_GAP       = TX_GAP;

  logic [1:0]       state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [47:0]      mac_q, mac_d;
  logic [31:0]      ip_q, ip_d;
  logic             oper_q, oper_d;
  logic             start_q, start_d;
  logic             reply_ack_q, reply_ack_d;
  logic             query_ack_q, query_ack_d;
  logic             timeout_q, timeout_d;
  logic [15:0]      tx_count_q, tx_count_d;

  logic [1:0] req, grant;
  logic       can_grant, advance;

  assign req = {bus.reply_req, bus.query_req};

  arb_rr2 u_arb (
    .clk       (aclk),
    .rst       (areset),
    .req_i     (req),
    .advance_i (advance),
    .grant_o   (grant)
  );

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    gap_d       = gap_q;
    mac_d       = mac_q;
    ip_d        = ip_q;
    oper_d      = oper_q;
    start_d     = 1'b0;
    reply_ack_d = 1'b0;
    query_ack_d = 1'b0;
    timeout_d   = 1'b0;
    tx_count_d  = tx_count_q;
    can_grant   = 1'b0;
    advance     = 1'b0;

    unique case (state_q)
      S_IDLE: can_grant = 1'b1;
      S_WAIT_DONE: begin
        // A done arriving on the expiry cycle still counts as a normal frame.
        if (bus.tx_frame_done) begin
          tx_count_d = tx_count_q + 16'd1;
          state_d    = S_GAP;
          gap_d      = '0;
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_GAP;
          gap_d     = '0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          can_grant = 1'b1;
          state_d   = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (can_grant && (req != 2'b00)) begin
      advance = 1'b1;
      start_d = 1'b1;
      state_d = S_WAIT_DONE;
      wd_d    = '0;
      if (grant[REQ_REPLY]) begin
        reply_ack_d = 1'b1;
        mac_d       = bus.reply_mac;
        ip_d        = bus.reply_ip;
        oper_d      = ARP_OPER_REPLY;
      end else if (grant[REQ_QUERY]) begin
        query_ack_d = 1'b1;
        mac_d       = MAC_BROADCAST;
        ip_d        = bus.query_ip;
        oper_d      = ARP_OPER_REQUEST;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      wd_q        <= '0;
      gap_q       <= '0;
      mac_q       <= '0;
      ip_q        <= '0;
      oper_q      <= 1'b0;
      start_q     <= 1'b0;
      reply_ack_q <= 1'b0;
      query_ack_q <= 1'b0;
      timeout_q   <= 1'b0;
      tx_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      gap_q       <= gap_d;
      mac_q       <= mac_d;
      ip_q        <= ip_d;
      oper_q      <= oper_d;
      start_q     <= start_d;
      reply_ack_q <= reply_ack_d;
      query_ack_q <= query_ack_d;
      timeout_q   <= timeout_d;
      tx_count_q  <= tx_count_d;
    end
  end

  assign bus.reply_ack      = reply_ack_q;
  assign bus.query_ack      = query_ack_q;
  assign bus.tx_frame_start = start_q;
  assign bus.mac_d_addr     = mac_q;
  assign bus.ip_d_addr      = ip_q;
  assign bus.arp_oper       = oper_q;
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.timeout_err    = timeout_q;
  assign bus.tx_count       = tx_count_q;
endmodule

// File: tb/tb_eth_tx_sched.sv
// Scenario tests plus a randomized run checked against a timing-rule model.
module tb_eth_tx_sched;
  import eth_pkg::*;

  localparam int IFG = 12;
  localparam int TMO = 256;

  logic aclk = 1'b0;
  logic areset;
  eth_tx_sched_if bus ();

  eth_tx_sched #(.IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TMO)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  task automatic tick();
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.reply_req     = 1'b0;
    bus.reply_mac     = '0;
    bus.reply_ip      = '0;
    bus.query_req     = 1'b0;
    bus.query_ip      = '0;
    bus.tx_frame_done = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    idle_inputs();
    tick();
    areset = 1'b0;
  endtask

  task automatic pulse_done();
    bus.tx_frame_done = 1'b1;
    tick();
    bus.tx_frame_done = 1'b0;
  endtask

  // Returns the number of ticks until tx_frame_start, or -1 if it never came.
  task automatic wait_start(input int max_ticks, output int n);
    n = -1;
    for (int i = 1; i <= max_ticks; i++) begin
      tick();
      if (bus.tx_frame_start === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  function automatic logic [161:0] all_outputs();
    return {bus.reply_ack, bus.query_ack, bus.tx_frame_start, bus.mac_d_addr,
            bus.ip_d_addr, bus.arp_oper, bus.busy, bus.timeout_err, bus.tx_count};
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if (all_outputs() !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", all_outputs());
    end
  endtask

  task automatic test_reply_only();
    do_reset();
    bus.reply_req = 1'b1;
    bus.reply_mac = 48'h02_00_00_00_00_01;
    bus.reply_ip  = 32'hC0A8_010A;
    tick();
    checks++;
    if ({bus.tx_frame_start, bus.reply_ack, bus.query_ack, bus.busy} !== 4'b1101) begin
      fails++; $display("FAIL reply_grant_flags: got %b expected 1101",
                        {bus.tx_frame_start, bus.reply_ack, bus.query_ack, bus.busy});
    end
    checks++;
    if ({bus.mac_d_addr, bus.ip_d_addr, bus.arp_oper} !== {48'h020000000001, 32'hC0A8010A, 1'b1}) begin
      fails++; $display("FAIL reply_grant_addr: got %h %h %b expected 020000000001 c0a8010a 1",
                        bus.mac_d_addr, bus.ip_d_addr, bus.arp_oper);
    end
    bus.reply_req = 1'b0;
    tick();
    checks++;
    if ({bus.tx_frame_start, bus.reply_ack} !== 2'b00) begin
      fails++; $display("FAIL reply_pulse_width: got %b expected 00", {bus.tx_frame_start, bus.reply_ack});
    end
    pulse_done();
    checks++;
    if (bus.tx_count !== 16'd1) begin
      fails++; $display("FAIL reply_count: got %0d expected 1", bus.tx_count);
    end
    repeat (IFG - 1) tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      fails++; $display("FAIL gap_last_busy: got %b expected 1", bus.busy);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      fails++; $display("FAIL gap_end_idle: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_tie();
    logic [47:0] r_mac;
    logic [31:0] r_ip, q_ip;
    int n;
    do_reset();
    r_mac = {16'($urandom), 32'($urandom)};
    r_ip  = $urandom;
    q_ip  = $urandom;
    bus.reply_req = 1'b1; bus.reply_mac = r_mac; bus.reply_ip = r_ip;
    bus.query_req = 1'b1; bus.query_ip  = q_ip;
    tick();
    checks++;
    if ({bus.tx_frame_start, bus.reply_ack, bus.query_ack, bus.mac_d_addr, bus.arp_oper} !==
        {3'b110, r_mac, 1'b1}) begin
      fails++; $display("FAIL tie_first_reply: got %b%b%b %h %b expected 110 %h 1", bus.tx_frame_start,
                        bus.reply_ack, bus.query_ack, bus.mac_d_addr, bus.arp_oper, r_mac);
    end
    bus.reply_req = 1'b0;
    repeat ($urandom_range(0, 10)) tick();
    pulse_done();
    wait_start(IFG + 10, n);
    checks++;
    if (n !== IFG) begin
      fails++; $display("FAIL tie_query_spacing: got %0d expected %0d ticks after gap start", n, IFG);
    end
    checks++;
    if ({bus.query_ack, bus.reply_ack, bus.mac_d_addr, bus.ip_d_addr, bus.arp_oper} !==
        {2'b10, MAC_BROADCAST, q_ip, 1'b0}) begin
      fails++; $display("FAIL tie_query_grant: got %b%b %h %h %b expected 10 %h %h 0", bus.query_ack,
                        bus.reply_ack, bus.mac_d_addr, bus.ip_d_addr, bus.arp_oper, MAC_BROADCAST, q_ip);
    end
    bus.query_req = 1'b0;
  endtask

  task automatic test_watchdog();
    int n = -1;
    do_reset();
    bus.query_req = 1'b1;
    bus.query_ip  = 32'h0A00_0001;
    tick();
    bus.query_req = 1'b0;
    for (int i = 1; i <= TMO + 20; i++) begin
      tick();
      if (bus.timeout_err === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n !== TMO) begin
      fails++; $display("FAIL watchdog_latency: got %0d expected %0d", n, TMO);
    end
    checks++;
    if (bus.tx_count !== 16'd0) begin
      fails++; $display("FAIL watchdog_count: got %0d expected 0", bus.tx_count);
    end
    tick();
    checks++;
    if (bus.timeout_err !== 1'b0) begin
      fails++; $display("FAIL watchdog_single_pulse: got %b expected 0", bus.timeout_err);
    end
    repeat (IFG - 2) tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      fails++; $display("FAIL watchdog_gap_busy: got %b expected 1", bus.busy);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      fails++; $display("FAIL watchdog_busy_drop: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_done_at_timeout();
    bit early = 1'b0;
    do_reset();
    bus.reply_req = 1'b1;
    bus.reply_mac = 48'h0A0B_0C0D_0E0F;
    bus.reply_ip  = 32'h0102_0304;
    tick();
    bus.reply_req = 1'b0;
    for (int i = 1; i < TMO; i++) begin
      tick();
      if (bus.timeout_err !== 1'b0) early = 1'b1;
    end
    pulse_done();
    checks++;
    if ({early, bus.timeout_err} !== 2'b00) begin
      fails++; $display("FAIL done_vs_timeout_err: got %b expected 00", {early, bus.timeout_err});
    end
    checks++;
    if (bus.tx_count !== 16'd1) begin
      fails++; $display("FAIL done_vs_timeout_count: got %0d expected 1", bus.tx_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    bus.reply_req = 1'b1;
    bus.reply_mac = {16'($urandom), 32'($urandom)};
    bus.reply_ip  = $urandom;
    tick();
    bus.reply_req = 1'b0;
    repeat ($urandom_range(1, 20)) tick();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    checks++;
    if (all_outputs() !== '0) begin
      fails++; $display("FAIL reset_mid_frame: got %h expected 0", all_outputs());
    end
    pulse_done();
    checks++;
    if ({bus.tx_count, bus.busy} !== 17'd0) begin
      fails++; $display("FAIL late_done_ignored: got count %0d busy %b expected 0 0", bus.tx_count, bus.busy);
    end
  endtask

  task automatic test_ignored_inputs();
    int n;
    do_reset();
    pulse_done();
    checks++;
    if ({bus.tx_count, bus.busy} !== 17'd0) begin
      fails++; $display("FAIL idle_done_ignored: got count %0d busy %b expected 0 0", bus.tx_count, bus.busy);
    end
    bus.reply_req = 1'b1;
    tick();
    bus.reply_req = 1'b0;
    pulse_done();
    bus.query_req = 1'b1;
    pulse_done();
    bus.query_req = 1'b0;
    checks++;
    if (bus.tx_count !== 16'd1) begin
      fails++; $display("FAIL gap_done_ignored: got %0d expected 1", bus.tx_count);
    end
    wait_start(IFG + 5, n);
    checks++;
    if (n !== -1) begin
      fails++; $display("FAIL dropped_request_granted: got start after %0d ticks expected none", n);
    end
  endtask

  // Model: a start appears once a request is pending and the gap since the last
  // done (IFG cycles) has elapsed; ties go to the requester not served last.
  task automatic test_random();
    bit p_rep = 0, p_qry = 0, last_rep = 0, in_frame = 0;
    bit exp_start, win_rep, done_now;
    logic [47:0] r_mac = '0;
    logic [31:0] r_ip = '0, q_ip = '0;
    logic [15:0] m_count = '0;
    int ready = 0, done_at = -1;
    do_reset();
    for (int step = 0; step < 3000; step++) begin
      if (!p_rep && $urandom_range(0, 9) == 0) begin
        r_mac = {16'($urandom), 32'($urandom)};
        r_ip  = $urandom;
        p_rep = 1'b1;
        bus.reply_req = 1'b1; bus.reply_mac = r_mac; bus.reply_ip = r_ip;
      end
      if (!p_qry && $urandom_range(0, 9) == 0) begin
        q_ip  = $urandom;
        p_qry = 1'b1;
        bus.query_req = 1'b1; bus.query_ip = q_ip;
      end
      exp_start = !in_frame && (p_rep || p_qry) && (cyc + 1 >= ready);
      win_rep   = p_rep && (!p_qry || !last_rep);
      done_now  = in_frame && (cyc == done_at);
      bus.tx_frame_done = done_now;
      if (done_now) begin
        m_count  = m_count + 16'd1;
        ready    = cyc + 1 + IFG;
        in_frame = 1'b0;
      end
      tick();
      checks++;
      if (bus.tx_frame_start !== exp_start) begin
        fails++; $display("FAIL rand_start @%0d: got %b expected %b", cyc, bus.tx_frame_start, exp_start);
      end
      if (exp_start) begin
        checks++;
        if ({bus.reply_ack, bus.query_ack} !== {win_rep, !win_rep}) begin
          fails++; $display("FAIL rand_ack @%0d: got %b%b expected %b%b", cyc,
                            bus.reply_ack, bus.query_ack, win_rep, !win_rep);
        end
        checks++;
        if ({bus.mac_d_addr, bus.ip_d_addr, bus.arp_oper} !==
            (win_rep ? {r_mac, r_ip, 1'b1} : {MAC_BROADCAST, q_ip, 1'b0})) begin
          fails++; $display("FAIL rand_addr @%0d: got %h %h %b expected reply=%b", cyc,
                            bus.mac_d_addr, bus.ip_d_addr, bus.arp_oper, win_rep);
        end
        last_rep = win_rep;
        in_frame = 1'b1;
        done_at  = cyc + $urandom_range(0, 20);
        if (win_rep) begin p_rep = 1'b0; bus.reply_req = 1'b0; end
        else begin p_qry = 1'b0; bus.query_req = 1'b0; end
      end
      if (done_now) begin
        checks++;
        if (bus.tx_count !== m_count) begin
          fails++; $display("FAIL rand_count @%0d: got %0d expected %0d", cyc, bus.tx_count, m_count);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_count_wrap();
    do_reset();
    force dut.tx_count_q = 16'hFFFF;
    tick();
    release dut.tx_count_q;
    tick();
    checks++;
    if (bus.tx_count !== 16'hFFFF) begin
      fails++; $display("FAIL wrap_preload: got %h expected ffff", bus.tx_count);
    end
    bus.query_req = 1'b1;
    tick();
    bus.query_req = 1'b0;
    tick();
    pulse_done();
    checks++;
    if (bus.tx_count !== 16'h0000) begin
      fails++; $display("FAIL wrap_to_zero: got %h expected 0000", bus.tx_count);
    end
  endtask

  initial begin
    areset = 1'b1;
    idle_inputs();
    test_reset();
    test_reply_only();
    test_tie();
    test_watchdog();
    test_done_at_timeout();
    test_reset_mid_frame();
    test_ignored_inputs();
    test_random();
    test_count_wrap();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation still running, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/eth_tx_sched.md
# eth_tx_sched

Transmit scheduler in front of the Ethernet TX frame builder. It arbitrates between two ARP requesters, an ARP reply source fed from the RX path and an ARP query source driven by the host. It latches the granted requester's addressing, issues a single `tx_frame_start` and waits for `tx_frame_done`. It then enforces an inter-frame gap and guards against a hung builder with a watchdog timeout.

## Interface
- `IFG_CYCLES`, default 12: idle cycles forced after each frame; must be ≥1.
- `TIMEOUT_CYCLES`, default 256: maximum cycles from `tx_frame_start` to `tx_frame_done`.
- `aclk` in 1: clock, all logic on rising edge.
- `areset` in 1: synchronous reset, active-high. One clock; reset is synchronous and active-high.
- `reply_req` in 1: ARP reply pending; level, held until `reply_ack`.
- `reply_mac` in 48: target MAC for the reply; stable while `reply_req` is high.
- `reply_ip` in 32: target IP for the reply; stable while `reply_req` is high.
- `reply_ack` out 1: one-cycle pulse; the reply has been granted.
- `query_req` in 1: ARP request (who-has) pending; level, held until `query_ack`.
- `query_ip` in 32: IP being resolved.
- `query_ack` out 1: one-cycle pulse; the query has been granted.
- `tx_frame_start` out 1: one-cycle pulse to the frame builder.
- `tx_frame_done` in 1: frame-complete pulse from the frame builder.
- `mac_d_addr` out 48: destination MAC to the builder.
- `ip_d_addr` out 32: destination IP to the builder.
- `arp_oper` out 1: 0 = request (oper 1), 1 = reply (oper 2).
- `busy` out 1: high whenever state ≠ IDLE.
- `timeout_err` out 1: one-cycle pulse when the watchdog expires.
- `tx_count` out 16: frames completed normally; wraps at 0xFFFF → 0.

## Operation
- States: IDLE, WAIT_DONE, GAP.
- **IDLE.** If either request is high, grant at the next edge:
  - `tx_frame_start`, the matching ack, `mac_d_addr`, `ip_d_addr` and `arp_oper` all update on the same edge.
  - State → WAIT_DONE and the watchdog counter clears.
- **Grant contents.**
  - Reply grant: `mac_d_addr` = `reply_mac`, `ip_d_addr` = `reply_ip`, `arp_oper` = 1.
  - Query grant: `mac_d_addr` = 48'hFFFF_FFFF_FFFF, `ip_d_addr` = `query_ip`, `arp_oper` = 0.
- **Arbitration.** Two-way round-robin on a `last_grant` flag (reset value = query).
  - When both requests are high, the requester not granted last wins, so the first tie after reset goes to reply.
  - A single requester always wins.
- **Address hold.** Address and `arp_oper` outputs hold their value until the next grant; the builder samples them throughout the frame.
- **WAIT_DONE.**
  - On `tx_frame_done`: `tx_count` increments by 1, state → GAP.
  - Otherwise the watchdog counter increments. When it reaches TIMEOUT_CYCLES−1 without `done`: `timeout_err` pulses, state → GAP, `tx_count` unchanged.
- **GAP.** Gap counter runs 0..IFG_CYCLES−1. On the last value, behave exactly as IDLE: grant if a request is pending, otherwise go to IDLE.
- **Ignored inputs.**
  - `tx_frame_done` outside WAIT_DONE has no effect.
  - A request that drops before being acked is lost without error.
- **Reset values.** All outputs 0 (including addresses), state IDLE, counters 0, `last_grant` = query. Reset mid-frame abandons the frame and issues no ack.
- **Counter widths.** Watchdog counter is $clog2(TIMEOUT_CYCLES) bits; gap counter is $clog2(IFG_CYCLES+1) bits.

## Timing
- Latency from a request rising in cycle n (while IDLE) to ack and `tx_frame_start` high: cycle n+1.
- With `tx_frame_done` high in cycle d:
  - GAP covers cycles d+1..d+IFG_CYCLES.
  - Earliest next `tx_frame_start` is cycle d+IFG_CYCLES+1.
- Back-to-back frames are spaced by exactly IFG_CYCLES+1 cycles from `done` to `start`.
- `done` and watchdog expiry in the same cycle: `done` wins; no `timeout_err`, and `tx_count` increments.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `eth_pkg` holds:
  - state enum `tx_sched_state_t`
  - `ARP_OPER_REQUEST` = 1'b0 and `ARP_OPER_REPLY` = 1'b1
  - `MAC_BROADCAST` = 48'hFFFF_FFFF_FFFF
- Natural sub-module: `arb_rr2`, a 2-input round-robin arbiter (req[1:0], advance → one-hot grant). It is reused later when the UDP source joins.
- Scheduler FSM, counters and address registers live in the top module.

## Test plan
- **Reply only.** `reply_req` = 1, `reply_mac` = 02:00:00:00:00:01, `reply_ip` = 192.168.1.10 → next cycle `reply_ack` = `tx_frame_start` = 1, `mac_d_addr` = 0x020000000001, `ip_d_addr` = 0xC0A8010A, `arp_oper` = 1.
- **Tie.** Both requests high after reset → reply granted first. Query granted exactly 13 cycles after reply's `done` (IFG_CYCLES = 12), with `mac_d_addr` = broadcast and `arp_oper` = 0.
- **Watchdog.** No `tx_frame_done` after start → `timeout_err` pulses once, 256 cycles after start. `tx_count` unchanged, `busy` drops 12 cycles later.
- **Done at the timeout edge.** `done` asserted in the cycle the watchdog would expire → no `timeout_err`, `tx_count` +1.
- **Reset mid-frame.** `areset` = 1 during WAIT_DONE → next cycle all outputs 0 and state IDLE. A `tx_frame_done` arriving afterwards is ignored.
- **Count wrap.** Preload to 0xFFFF via 65535 frames (or force) plus one more → `tx_count` = 0x0000.
